// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between two requesters.
// One access per SERVE cycle; read data is registered back to the granted port.
module data_memory_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData,
  output logic              busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  logic [0:0]        state;
  logic              last;
  logic              lat_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              win1;
  logic              serving;

  // Port 1 wins when alone, or on a tie when port 0 was granted last.
  assign win1    = req1 & (~req0 | ~last);
  assign serving = (state == SERVE);

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= SERVE;
            lat_id    <= win1;
            last      <= win1;
            lat_we    <= win1 ? we1 : we0;
            lat_addr  <= win1 ? addr1 : addr0;
            lat_wdata <= win1 ? wdata1 : wdata0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= serving & ~lat_we & ~lat_id;
      rvalid1 <= serving & ~lat_we & lat_id;
      if (serving && !lat_we && !lat_id) rdata0 <= mem_readData;
      if (serving && !lat_we && lat_id)  rdata1 <= mem_readData;
    end
  end

  // Everything below is decoded from registers only; no input reaches an output.
  assign gnt0          = serving & ~lat_id;
  assign gnt1          = serving & lat_id;
  assign busy          = serving;
  assign mem_address   = lat_addr;
  assign mem_writeData = lat_wdata;
  assign mem_memWrite  = serving & lat_we;
  assign mem_memRead   = serving & ~lat_we;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter with a behavioural 32-word data memory
// (word i initialised to i, selected by address[31:27], written at negedge).
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_memWrite, mem_memRead, busy;
  logic [31:0] rdata0, rdata1, mem_address, mem_writeData, mem_readData;

  logic [31:0] mem [32];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clock_in(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData), .busy(busy)
  );

  initial for (int i = 0; i < 32; i++) mem[i] = 32'(i);
  always @(negedge clk) if (mem_memWrite) mem[mem_address[31:27]] <= mem_writeData;
  assign mem_readData = mem[mem_address[31:27]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each rvalid pops the value pushed when its read was granted.
  always @(negedge clk) begin
    if (gnt0 && gnt1) check("gnt_exclusive", {gnt0, gnt1}, 32'd0);
    if (rvalid0) begin
      if (q0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
      else check("rdata0", rdata0, q0.pop_front());
    end
    if (rvalid1) begin
      if (q1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
      else check("rdata1", rdata1, q1.pop_front());
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  // Single access from idle: grant expected at the second negedge after driving.
  task automatic access(input vec_t v);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    @(posedge clk); #1;
    if (v.port) begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else        begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = v.port ? gnt1 : gnt0;
    end
    check("gnt_latency", 32'(n), 32'd2);
    if (got) begin
      if (!v.we) begin
        if (v.port) q1.push_back(v.exp); else q0.push_back(v.exp);
      end
      check("other_gnt", 32'(v.port ? gnt0 : gnt1), 32'd0);
      check("mem_address", mem_address, v.addr);
      check("mem_memWrite", 32'(mem_memWrite), 32'(v.we));
      check("mem_memRead", 32'(mem_memRead), 32'(!v.we));
      if (v.we) check("mem_writeData", mem_writeData, v.wdata);
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    @(negedge clk);
    if (v.we) check("no_rvalid_on_write", 32'(v.port ? rvalid1 : rvalid0), 32'd0);
    check("idle_memWrite", 32'(mem_memWrite), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  vec_t tbl [6];
  int   order [4];
  int   ng, g1cnt, wcnt;

  initial begin
    tbl[0] = '{0, 0, 32'h1800_0000, 32'h0,         32'd3};
    tbl[1] = '{1, 1, 32'h2800_0000, 32'hDEAD_BEEF, 32'h0};
    tbl[2] = '{0, 0, 32'h2800_0000, 32'h0,         32'hDEAD_BEEF};
    tbl[3] = '{1, 0, 32'h0000_0000, 32'h0,         32'd0};
    tbl[4] = '{0, 1, 32'hF800_0000, 32'h0000_CAFE, 32'h0};
    tbl[5] = '{1, 0, 32'hF800_0004, 32'h0,         32'h0000_CAFE};

    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("reset_memrw", {30'd0, mem_memRead, mem_memWrite}, 32'd0);
    do_reset();

    access(tbl[0]);

    // Async reset mid-SERVE before the write's negedge: write must be aborted.
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h2800_0000; wdata0 = 32'h1234_5678;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("abort_gnt0", 32'(gnt0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_memWrite", 32'(mem_memWrite), 32'd0);
    check("abort_memRead", 32'(mem_memRead), 32'd0);
    check("abort_address", mem_address, 32'd0);
    check("abort_writeData", mem_writeData, 32'd0);
    check("abort_rdata0", rdata0, 32'd0);
    req0 = 0; we0 = 0;
    @(posedge clk); #1 rst_n = 1;
    access('{0, 0, 32'h2800_0000, 32'h0, 32'd5});

    for (int i = 1; i < 6; i++) access(tbl[i]);

    // Both ports requesting continuously from a fresh reset: 0,1,0,1.
    do_reset();
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 32'h0800_0000;
    req1 = 1; we1 = 0; addr1 = 32'h1000_0000;
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      @(negedge clk);
      if (gnt0) begin order[ng] = 0; ng++; q0.push_back(32'd1); end
      if (gnt1) begin order[ng] = 1; ng++; q1.push_back(32'd2); end
    end
    @(posedge clk); #1 req0 = 0; req1 = 0;
    check("rr_grant_count", 32'(ng), 32'd4);
    for (int k = 0; k < 4; k++) check("rr_order", 32'(order[k]), 32'(k % 2));
    repeat (3) @(negedge clk);

    // Port 0 holds req for three reads: grants every 2 cycles, no duplicate.
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 32'h2000_0000;
    ng = 0;
    begin
      int last_c, c;
      last_c = 0;
      c = 0;
      while (ng < 3 && c < 20) begin
        @(negedge clk);
        c++;
        if (gnt0) begin
          if (ng > 0) check("hold_spacing", 32'(c - last_c), 32'd2);
          last_c = c;
          ng++;
          q0.push_back(32'd4);
        end
      end
    end
    @(posedge clk); #1 req0 = 0;
    repeat (4) begin
      @(negedge clk);
      if (gnt0) ng++;
    end
    check("hold_gnt_count", 32'(ng), 32'd3);

    // req1 pulses only inside port 0's SERVE cycle and must be ignored.
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 32'h1800_0000;
    @(posedge clk); #1;
    req1 = 1; we1 = 1; addr1 = 32'h3800_0000; wdata1 = 32'hBAD0_BAD0;
    q0.push_back(32'd3);
    #5 req1 = 0;
    @(posedge clk); #1 req0 = 0;
    g1cnt = 0;
    wcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (gnt1) g1cnt++;
      if (mem_memWrite) wcnt++;
    end
    check("drop_no_gnt1", 32'(g1cnt), 32'd0);
    check("drop_no_write", 32'(wcnt), 32'd0);
    check("drop_mem_untouched", mem[7], 32'd7);

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-requester arbiter that shares the single-ported data memory between the CPU load/store path (port 0) and a second master such as a DMA or debug loader (port 1). It accepts one access at a time through a req/gnt handshake and uses round-robin priority. It drives the data memory's address, writeData, memWrite and memRead inputs, and registers the memory's combinational readData back to the granted requester. It sits between the requesters and data_memory and is the only block that drives the memory.

## Interface
- DATA_W, 32: data width of requester and memory data buses.
- ADDR_W, 32: address width. The address passes through unmodified; data_memory selects the word with address[31:27].
- clock_in  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req0, req1  in  1  access request from port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN.
- addr0, addr1  in  ADDR_W  access address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  one-cycle pulse: the request has been accepted.
- rvalid0, rvalid1  out  1  one-cycle pulse: rdataN holds read data.
- rdata0, rdata1  out  DATA_W  registered read data, held until the next read for that port.
- mem_address  out  ADDR_W  to data_memory address.
- mem_writeData  out  DATA_W  to data_memory writeData.
- mem_memWrite  out  1  to data_memory memWrite.
- mem_memRead  out  1  to data_memory memRead.
- mem_readData  in  DATA_W  from data_memory readData (combinational).
- busy  out  1  high while in SERVE state.

## Operation
- State machine with two states:
  - IDLE: sample req0/req1 at posedge.
  - SERVE: one memory cycle.
  - On any request in IDLE: latch the winner's we/addr/wdata and id, go to SERVE.
  - SERVE always returns to IDLE on the next posedge.
- Arbitration is round-robin on `last` (id of the most recently granted port).
  - Single request: that requester wins.
  - Both requesting: the port != last wins.
  - `last` updates on every grant.
  - `last` resets to 1, so port 0 wins the first tie.
- gntN is registered and high exactly during the SERVE cycle of port N's access. gnt0 and gnt1 are never high together.
- Memory-side outputs are driven only from latched registers:
  - In SERVE: mem_address = latched addr; mem_writeData = latched wdata; mem_memWrite = latched we; mem_memRead = ~latched we.
  - In IDLE: mem_memWrite = 0, mem_memRead = 0. mem_address and mem_writeData hold their last values.
- Write: data_memory commits at the negedge inside the SERVE cycle. No rvalid is generated for a write.
- Read: mem_readData is captured into rdataN at the posedge that ends SERVE. rvalidN pulses for exactly the following cycle.
- Requester rules:
  - Hold reqN, weN, addrN and wdataN stable until the posedge at which it samples gntN = 1.
  - At that edge the requester may drop req or present a new request.
  - reqN sampled at the SERVE-ending posedge is ignored. This prevents double grants.
- Dropping req before it is granted withdraws the request and has no side effect.
- Reset (reset = 0, async, mid-operation included):
  - State goes to IDLE; last = 1.
  - gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0, busy = 0.
  - mem_memWrite = 0 and mem_memRead = 0 immediately; mem_address = 0 and mem_writeData = 0.
  - An in-flight write that has not reached its negedge is aborted.
  - Latched request registers are cleared.

## Timing
- Request sampled at posedge P0 → SERVE and gnt during cycle P0..P1.
- Write commits at the negedge within that cycle.
- Read: rdata captured at P1; rvalid high during P1..P2.
- Read latency from the sampling edge: 2 cycles.
- Peak throughput: one access every 2 cycles. A continuously requesting port alternates with the other every 4 cycles.
- No combinational path from any req/we/addr/wdata input to any output.

## Test plan
- Reset release, then req0 = 1 read at addr0 = 32'h1800_0000 → gnt0 one cycle later; rvalid0 the cycle after with rdata0 = 3; gnt1, rvalid1, mem_memWrite stay 0.
- Port 1 write of 32'hDEAD_BEEF to 32'h2800_0000, then port 0 read of the same address → rdata0 = 32'hDEAD_BEEF; no rvalid1 pulse after the write.
- req0 and req1 both held high continuously, reads at indices 1 and 2 → gnt order 0,1,0,1; rdata0 = 1 and rdata1 = 2 on alternating rvalids; gnt0 and gnt1 never high together.
- Single requester holds req0 high for 3 accesses → exactly 3 gnt0 pulses spaced 2 cycles apart; no duplicate grant on the gnt edge.
- reset driven low mid-SERVE during a port 0 write of 32'h1234_5678 to index 5, before the negedge → all outputs 0 asynchronously; a later read of index 5 returns 5.
- req1 raised then dropped before arbiter samples (while SERVE for port 0) → no gnt1; mem_memWrite never asserted for port 1's data.
